fetch_decode_ctrl: RTL and testbench
====================================

Name: fetch_decode_ctrl

Overview:
- Multi-cycle control unit directly upstream of the datapath.
- Fetches a 16-bit instruction from memory port A at the PC and latches it into an instruction register.
- Decodes the instruction and drives every datapath control: register-mux selects, register write enables, ALU opcode/immediate, memory write, PC enable/load and the write-back source select.
- Executes ALU reg/imm, LOAD, STOR and JCOND instructions.

Parameters:
- NUM_REGS, 16, number of registers; fixes the reg_en width and the 4-bit register fields.
- DATA_W, 16, instruction and immediate width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces state and instruction register to reset values immediately.
- mem_data  input  16  memory port A read data; valid the cycle after its address is presented (synchronous read).
- flags  input  5  ALU flags: [0]=C, [1]=L, [2]=F, [3]=Z, [4]=N.
- opcode  output  16  latched instruction register (ir), driven to the ALU.
- imm_val  output  16  ir[7:0] sign-extended to 16 bits.
- imm_sel  output  1  1 = ALU B operand is imm_val.
- mux_a_sel  output  4  register mux A select.
- mux_b_sel  output  4  register mux B select.
- reg_en  output  16  one-hot register write enable.
- alu_sel  output  1  write-back source: 1 = ALU, 0 = memory.
- flag_en  output  1  flag register update strobe.
- w_en_a  output  1  memory port A write.
- pc_sel  output  1  memory address source: 1 = PC, 0 = mux A.
- pc_en  output  1  PC update this cycle.
- pc_ld  output  1  with pc_en: load PC from mux A instead of incrementing.
- state  output  2  current state, for debug.

Behaviour:
- Instruction fields: op = ir[15:12], rd = ir[11:8], ext = ir[7:4], rs = ir[3:0].
- Classes:
  - op=0000: R-type ALU.
  - op=0100: special; ext 0000 = LOAD, 0100 = STOR, 1100 = JCOND. Any other ext is a NOP.
  - Any other op: immediate ALU.
- Compare (no write-back): R-type with ext=1011, or immediate with op=1011.
- States (2-bit): FETCH=0, DECODE=1, EXEC=2, MEMRD=3.
- Outputs are combinational from state and ir. Every signal not listed for a state is 0.
- FETCH: pc_sel=1. Next state DECODE.
- DECODE: pc_sel=1. ir <= mem_data at the clock edge. Next state EXEC.
- EXEC, ALU instruction:
  - mux_a_sel=rd, mux_b_sel=rs, imm_sel=1 for immediate class.
  - alu_sel=1, flag_en=1, pc_en=1.
  - reg_en=1<<rd, except for compares, where reg_en=0.
  - Next state FETCH.
- EXEC, LOAD: mux_a_sel=rs, pc_sel=0 (address = rs). Next state MEMRD.
- MEMRD: mux_a_sel=rs, pc_sel=0, alu_sel=0, reg_en=1<<rd, pc_en=1. Next state FETCH.
- EXEC, STOR:
  - mux_a_sel=rs (address), mux_b_sel=rd (data), pc_sel=0.
  - w_en_a=1, pc_en=1.
  - Next state FETCH.
- EXEC, JCOND:
  - mux_a_sel=rs, pc_en=1, pc_ld=taken(rd, flags).
  - Next state FETCH.
- JCOND conditions, indexed by rd:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - 12 LT: !L & !Z
  - 13 GE: L | Z
  - 14 UC: 1
  - 10, 11, 15: never taken.
- EXEC, special NOP: pc_en=1 only. Next state FETCH.
- Latencies: ALU/STOR/JCOND take 3 cycles per instruction; LOAD takes 4.
- At most one pc_en pulse per instruction. w_en_a and reg_en are never asserted in FETCH or DECODE.
- Reset values: state=FETCH, ir=0. Resulting outputs: pc_sel=1, all other outputs 0, opcode=0, imm_val=0.
- Reset mid-instruction: the FSM aborts with no write strobe; the next fetch starts from the PC (the PC resets externally).
- reg_en is always one-hot or zero.
- rd=rs (e.g. ADD r3,r3) is legal; no special case.

Decomposition:
- Package ctrl_defs:
  - state encodings;
  - op/ext constants (OP_RTYPE, OP_SPECIAL, EXT_LOAD, EXT_STOR, EXT_JCOND, EXT_CMP, OP_CMPI);
  - condition codes;
  - flag bit indices.
- One combinational sub-module, cond_eval(cond[3:0], flags[4:0]) -> taken, used by the JCOND path.

Test Plan:
- reset asserted mid-EXEC of ADD r3,r4 (0x0354) -> state=0, reg_en=0, pc_sel=1 immediately, asynchronously; ir=0.
- mem_data=0x0354 during DECODE -> in EXEC: opcode=0x0354, mux_a_sel=3, mux_b_sel=4, reg_en=0x0008, alu_sel=1, flag_en=1, pc_en=1; back in FETCH next cycle.
- CMPI r2,#-1 (0xB2FF) -> imm_sel=1, imm_val=0xFFFF, flag_en=1, reg_en=0.
- LOAD r5,[r7] (0x4507) -> EXEC: pc_sel=0, mux_a_sel=7, reg_en=0. MEMRD: alu_sel=0, reg_en=0x0020, pc_en=1. Four cycles from FETCH to FETCH.
- STOR r1,[r9] (0x4149) -> EXEC: w_en_a=1, mux_a_sel=9, mux_b_sel=1, pc_sel=0 for exactly one cycle.
- JCOND EQ,r6 (0x40C6):
  - flags=0x08 -> pc_en=1, pc_ld=1, mux_a_sel=6.
  - flags=0x00 -> pc_en=1, pc_ld=0.
  - cond 15 (0x4FC6) -> pc_ld=0 regardless of flags.

Source files
------------

// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared encodings for the fetch/decode control unit: FSM states, opcode and
// extension fields, jump condition codes and ALU flag bit positions.
package ctrl_defs;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_MEMRD  = 2'd3
    } state_e;

    localparam logic [3:0] OP_RTYPE   = 4'h0;
    localparam logic [3:0] OP_SPECIAL = 4'h4;
    localparam logic [3:0] OP_CMPI    = 4'hB;
    localparam logic [3:0] EXT_LOAD   = 4'h0;
    localparam logic [3:0] EXT_STOR   = 4'h4;
    localparam logic [3:0] EXT_JCOND  = 4'hC;
    localparam logic [3:0] EXT_CMP    = 4'hB;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GE = 4'd13;
    localparam logic [3:0] COND_UC = 4'd14;

    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

endpackage

// File: rtl/fetch_decode_ctrl_if.sv
// Bundle between the control unit (master) and the datapath/memory (slave).
interface fetch_decode_ctrl_if #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16
);
    logic [DATA_W-1:0]   mem_data;
    logic [4:0]          flags;
    logic [DATA_W-1:0]   opcode;
    logic [DATA_W-1:0]   imm_val;
    logic                imm_sel;
    logic [3:0]          mux_a_sel;
    logic [3:0]          mux_b_sel;
    logic [NUM_REGS-1:0] reg_en;
    logic                alu_sel;
    logic                flag_en;
    logic                w_en_a;
    logic                pc_sel;
    logic                pc_en;
    logic                pc_ld;
    logic [1:0]          state;

    modport master (
        input  mem_data, flags,
        output opcode, imm_val, imm_sel, mux_a_sel, mux_b_sel, reg_en,
               alu_sel, flag_en, w_en_a, pc_sel, pc_en, pc_ld, state
    );

    modport slave (
        output mem_data, flags,
        input  opcode, imm_val, imm_sel, mux_a_sel, mux_b_sel, reg_en,
               alu_sel, flag_en, w_en_a, pc_sel, pc_en, pc_ld, state
    );
endinterface

// File: rtl/fetch_decode_ctrl_cond_eval.sv
// Evaluates a JCOND condition code against the current ALU flags.
module cond_eval
    import ctrl_defs::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken =  flags[FLAG_Z];
            COND_NE: taken = !flags[FLAG_Z];
            COND_CS: taken =  flags[FLAG_C];
            COND_CC: taken = !flags[FLAG_C];
            COND_HI: taken =  flags[FLAG_L];
            COND_LS: taken = !flags[FLAG_L];
            COND_GT: taken =  flags[FLAG_N];
            COND_LE: taken = !flags[FLAG_N];
            COND_FS: taken =  flags[FLAG_F];
            COND_FC: taken = !flags[FLAG_F];
            COND_LT: taken = !flags[FLAG_L] && !flags[FLAG_Z];
            COND_GE: taken =  flags[FLAG_L] ||  flags[FLAG_Z];
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/execute controller: latches the instruction from
// memory port A and drives every datapath control from the state and ir.
module fetch_decode_ctrl
    import ctrl_defs::*;
#(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    fetch_decode_ctrl_if.master bus
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [3:0]        op, rd, ext, rs;
    logic              taken;
    logic              is_cmp;

    function automatic logic signed [DATA_W-1:0] sext8(input logic signed [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction

    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:8];
    assign ext = ir_q[7:4];
    assign rs  = ir_q[3:0];

    assign is_cmp = ((op == OP_RTYPE) && (ext == EXT_CMP)) || (op == OP_CMPI);

    cond_eval u_cond (
        .cond  (rd),
        .flags (bus.flags),
        .taken (taken)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.opcode  = ir_q;
    assign bus.imm_val = sext8(ir_q[7:0]);

    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        bus.imm_sel   = 1'b0;
        bus.mux_a_sel = '0;
        bus.mux_b_sel = '0;
        bus.reg_en    = '0;
        bus.alu_sel   = 1'b0;
        bus.flag_en   = 1'b0;
        bus.w_en_a    = 1'b0;
        bus.pc_sel    = 1'b0;
        bus.pc_en     = 1'b0;
        bus.pc_ld     = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.pc_sel = 1'b1;
                state_d    = S_DECODE;
            end
            // Memory read data for the PC address arrives here.
            S_DECODE: begin
                bus.pc_sel = 1'b1;
                ir_d       = bus.mem_data;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (op == OP_SPECIAL) begin
                    case (ext)
                        EXT_LOAD: begin
                            bus.mux_a_sel = rs;
                            state_d       = S_MEMRD;
                        end
                        EXT_STOR: begin
                            bus.mux_a_sel = rs;
                            bus.mux_b_sel = rd;
                            bus.w_en_a    = 1'b1;
                            bus.pc_en     = 1'b1;
                        end
                        EXT_JCOND: begin
                            bus.mux_a_sel = rs;
                            bus.pc_en     = 1'b1;
                            bus.pc_ld     = taken;
                        end
                        default: bus.pc_en = 1'b1;
                    endcase
                end else begin
                    bus.mux_a_sel = rd;
                    bus.mux_b_sel = rs;
                    bus.imm_sel   = (op != OP_RTYPE);
                    bus.alu_sel   = 1'b1;
                    bus.flag_en   = 1'b1;
                    bus.pc_en     = 1'b1;
                    if (!is_cmp) bus.reg_en = NUM_REGS'(1) << rd;
                end
            end
            // Second cycle of LOAD: write memory data back to rd.
            S_MEMRD: begin
                bus.mux_a_sel = rs;
                bus.reg_en    = NUM_REGS'(1) << rd;
                bus.pc_en     = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed-vector bench for fetch_decode_ctrl with hand-computed expectations.
module tb_fetch_decode_ctrl;
    logic clk;
    logic reset;
    int   errs;
    int   checks;

    fetch_decode_ctrl_if #(.NUM_REGS(16), .DATA_W(16)) bus ();

    fetch_decode_ctrl #(.NUM_REGS(16), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present instr, advance FETCH -> DECODE -> EXEC.
    task automatic to_exec(input logic [15:0] instr, input string tag);
        bus.mem_data = instr;
        chk({tag, "_fetch_state"}, 32'(bus.state), 32'd0);
        step();
        chk({tag, "_decode_state"}, 32'(bus.state), 32'd1);
        step();
        chk({tag, "_exec_state"}, 32'(bus.state), 32'd2);
        chk({tag, "_opcode"}, 32'(bus.opcode), 32'(instr));
    endtask

    initial begin
        errs = 0;
        checks = 0;
        reset = 1'b1;
        bus.mem_data = 16'h0000;
        bus.flags = 5'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pc_sel", 32'(bus.pc_sel), 32'd1);
        chk("rst_opcode", 32'(bus.opcode), 32'd0);
        chk("rst_imm_val", 32'(bus.imm_val), 32'd0);
        chk("rst_reg_en", 32'(bus.reg_en), 32'd0);
        chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD r3,r4
        to_exec(16'h0354, "add");
        chk("add_mux_a", 32'(bus.mux_a_sel), 32'd3);
        chk("add_mux_b", 32'(bus.mux_b_sel), 32'd4);
        chk("add_reg_en", 32'(bus.reg_en), 32'h0008);
        chk("add_alu_sel", 32'(bus.alu_sel), 32'd1);
        chk("add_flag_en", 32'(bus.flag_en), 32'd1);
        chk("add_pc_en", 32'(bus.pc_en), 32'd1);
        chk("add_imm_sel", 32'(bus.imm_sel), 32'd0);
        chk("add_w_en", 32'(bus.w_en_a), 32'd0);
        step();
        chk("add_back_fetch", 32'(bus.state), 32'd0);
        chk("add_fetch_reg_en", 32'(bus.reg_en), 32'd0);

        // CMPI r2,#-1
        to_exec(16'hB2FF, "cmpi");
        chk("cmpi_imm_sel", 32'(bus.imm_sel), 32'd1);
        chk("cmpi_imm_val", 32'(bus.imm_val), 32'hFFFF);
        chk("cmpi_flag_en", 32'(bus.flag_en), 32'd1);
        chk("cmpi_reg_en", 32'(bus.reg_en), 32'd0);
        chk("cmpi_mux_a", 32'(bus.mux_a_sel), 32'd2);
        step();

        // R-type compare CMP r1,r2 (ext=1011)
        to_exec(16'h01B2, "cmp");
        chk("cmp_reg_en", 32'(bus.reg_en), 32'd0);
        chk("cmp_imm_sel", 32'(bus.imm_sel), 32'd0);
        chk("cmp_flag_en", 32'(bus.flag_en), 32'd1);
        step();

        // ADDI r10,#5 (op=0001) writes r10
        to_exec(16'h1A05, "addi");
        chk("addi_reg_en", 32'(bus.reg_en), 32'h0400);
        chk("addi_imm_val", 32'(bus.imm_val), 32'h0005);
        chk("addi_imm_sel", 32'(bus.imm_sel), 32'd1);
        step();

        // LOAD r5,[r7]
        to_exec(16'h4507, "load");
        chk("load_pc_sel", 32'(bus.pc_sel), 32'd0);
        chk("load_mux_a", 32'(bus.mux_a_sel), 32'd7);
        chk("load_reg_en", 32'(bus.reg_en), 32'd0);
        chk("load_pc_en", 32'(bus.pc_en), 32'd0);
        step();
        chk("memrd_state", 32'(bus.state), 32'd3);
        chk("memrd_alu_sel", 32'(bus.alu_sel), 32'd0);
        chk("memrd_reg_en", 32'(bus.reg_en), 32'h0020);
        chk("memrd_pc_en", 32'(bus.pc_en), 32'd1);
        chk("memrd_mux_a", 32'(bus.mux_a_sel), 32'd7);
        chk("memrd_pc_sel", 32'(bus.pc_sel), 32'd0);
        step();
        chk("load_back_fetch", 32'(bus.state), 32'd0);

        // STOR r1,[r9]
        to_exec(16'h4149, "stor");
        chk("stor_w_en", 32'(bus.w_en_a), 32'd1);
        chk("stor_mux_a", 32'(bus.mux_a_sel), 32'd9);
        chk("stor_mux_b", 32'(bus.mux_b_sel), 32'd1);
        chk("stor_pc_sel", 32'(bus.pc_sel), 32'd0);
        chk("stor_pc_en", 32'(bus.pc_en), 32'd1);
        chk("stor_reg_en", 32'(bus.reg_en), 32'd0);
        step();
        chk("stor_w_en_off", 32'(bus.w_en_a), 32'd0);
        chk("stor_back_fetch", 32'(bus.state), 32'd0);

        // JCOND EQ,r6 taken / not taken
        bus.flags = 5'h08;
        to_exec(16'h40C6, "jeq_t");
        chk("jeq_t_pc_en", 32'(bus.pc_en), 32'd1);
        chk("jeq_t_pc_ld", 32'(bus.pc_ld), 32'd1);
        chk("jeq_t_mux_a", 32'(bus.mux_a_sel), 32'd6);
        step();
        bus.flags = 5'h00;
        to_exec(16'h40C6, "jeq_n");
        chk("jeq_n_pc_en", 32'(bus.pc_en), 32'd1);
        chk("jeq_n_pc_ld", 32'(bus.pc_ld), 32'd0);
        step();

        // cond 15 never taken, cond 14 always taken, LT/GE
        bus.flags = 5'h1F;
        to_exec(16'h4FC6, "j15");
        chk("j15_pc_ld", 32'(bus.pc_ld), 32'd0);
        step();
        bus.flags = 5'h00;
        to_exec(16'h4EC6, "juc");
        chk("juc_pc_ld", 32'(bus.pc_ld), 32'd1);
        step();
        to_exec(16'h4CC6, "jlt");
        chk("jlt_pc_ld", 32'(bus.pc_ld), 32'd1);
        bus.flags = 5'h02;
        #1;
        chk("jlt_l_pc_ld", 32'(bus.pc_ld), 32'd0);
        step();
        bus.flags = 5'h04;
        to_exec(16'h48C6, "jfs");
        chk("jfs_pc_ld", 32'(bus.pc_ld), 32'd1);
        step();

        // Special NOP (ext=0001)
        to_exec(16'h4312, "nop");
        chk("nop_pc_en", 32'(bus.pc_en), 32'd1);
        chk("nop_reg_en", 32'(bus.reg_en), 32'd0);
        chk("nop_w_en", 32'(bus.w_en_a), 32'd0);
        chk("nop_flag_en", 32'(bus.flag_en), 32'd0);
        step();

        // Asynchronous reset mid-EXEC of ADD r3,r4
        to_exec(16'h0354, "add2");
        chk("add2_reg_en", 32'(bus.reg_en), 32'h0008);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_state", 32'(bus.state), 32'd0);
        chk("arst_reg_en", 32'(bus.reg_en), 32'd0);
        chk("arst_pc_sel", 32'(bus.pc_sel), 32'd1);
        chk("arst_opcode", 32'(bus.opcode), 32'd0);
        chk("arst_pc_en", 32'(bus.pc_en), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        to_exec(16'h0354, "add3");
        chk("add3_reg_en", 32'(bus.reg_en), 32'h0008);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
